// File: rtl/delay_sequencer.sv
// delay_sequencer
// Pops timed steps (48-bit delay, 16-bit word) from a small FIFO and plays
// them through one external delay counter. The block owns the counter's
// load/value inputs and blanks the counter's expired level for a few
// cycles after each load so a stale expiry from the previous step is
// never mistaken for the new one.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | not running, out_word = IDLE_WORD, waiting for start with data
// LOAD  | dc_load/step pulse cycle, head entry is popped
// BLANK | dc_expired ignored while the counter settles on its new value
// WAIT  | waiting for dc_expired, then chain to next step or finish
module delay_sequencer #(
  parameter int          DEPTH     = 4,
  parameter logic [47:0] MIN_DELAY = 48'd2,
  parameter int          BLANK     = 2,
  parameter logic [15:0] IDLE_WORD = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [47:0]              push_delay,
  input  logic [15:0]              push_word,
  input  logic                     start,
  input  logic                     abort,
  output logic                     dc_load,
  output logic [47:0]              dc_l,
  input  logic                     dc_expired,
  output logic [15:0]              out_word,
  output logic                     step,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // Blank counter only needs to hold BLANK-1; keep at least one bit.
  localparam int BW = (BLANK < 2) ? 1 : $clog2(BLANK + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  // FIFO storage and bookkeeping
  logic [47:0]   mem_delay_q [DEPTH];
  logic [15:0]   mem_word_q  [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ready_q, push_ready_d;
  logic          push_fire;
  logic          pop_fire;

  // Sequencer state and registered outputs
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] blank_q, blank_d;
  logic          dc_load_q, dc_load_d;
  logic [47:0]   dc_l_q, dc_l_d;
  logic [15:0]   out_word_q, out_word_d;
  logic          step_q, step_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [47:0]   head_delay;
  logic [15:0]   head_word;
  logic [47:0]   head_delay_clamped;
  logic          go_load;

  assign head_delay         = mem_delay_q[rd_ptr_q];
  assign head_word          = mem_word_q[rd_ptr_q];
  assign head_delay_clamped = (head_delay < MIN_DELAY) ? MIN_DELAY : head_delay;

  // push_ready_q already implies room; abort discards a same-cycle push.
  assign push_fire = push_valid & push_ready_q & ~abort;
  // The head entry leaves the FIFO during the LOAD cycle itself.
  assign pop_fire  = (state_q == S_LOAD) & ~abort;

  // FIFO pointer/occupancy next-state; abort flushes everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_fire) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_fire, pop_fire})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
    push_ready_d = (level_d != LW'(DEPTH));
  end

  // FIFO entry storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_delay_q[wr_ptr_q] <= push_delay;
      mem_word_q[wr_ptr_q]  <= push_word;
    end
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      push_ready_q <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      push_ready_q <= push_ready_d;
    end
  end

  // Sequencer next-state; the LOAD outputs are set up on the transition
  // into LOAD so they appear registered in the LOAD cycle itself.
  always_comb begin
    state_d    = state_q;
    blank_d    = blank_q;
    dc_load_d  = 1'b0;
    dc_l_d     = dc_l_q;
    out_word_d = out_word_q;
    step_d     = 1'b0;
    done_d     = 1'b0;
    go_load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        out_word_d = IDLE_WORD;
        if (start && (level_q != '0)) begin
          go_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (BLANK == 0) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_BLANK;
          blank_d = BW'(BLANK - 1);
        end
      end
      S_BLANK: begin
        if (blank_q == '0) begin
          state_d = S_WAIT;
        end else begin
          blank_d = blank_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (dc_expired) begin
          if (level_q != '0) begin
            go_load = 1'b1;
          end else begin
            state_d    = S_IDLE;
            done_d     = 1'b1;
            out_word_d = IDLE_WORD;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        out_word_d = IDLE_WORD;
      end
    endcase

    if (go_load) begin
      state_d    = S_LOAD;
      dc_load_d  = 1'b1;
      dc_l_d     = head_delay_clamped;
      out_word_d = head_word;
      step_d     = 1'b1;
    end

    // Abort wins over everything, including a load about to be issued.
    if (abort) begin
      state_d    = S_IDLE;
      dc_load_d  = 1'b0;
      dc_l_d     = dc_l_q;
      out_word_d = IDLE_WORD;
      step_d     = 1'b0;
      done_d     = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      blank_q    <= '0;
      dc_load_q  <= 1'b0;
      dc_l_q     <= '0;
      out_word_q <= IDLE_WORD;
      step_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      blank_q    <= blank_d;
      dc_load_q  <= dc_load_d;
      dc_l_q     <= dc_l_d;
      out_word_q <= out_word_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign push_ready = push_ready_q;
  assign dc_load    = dc_load_q;
  assign dc_l       = dc_l_q;
  assign out_word   = out_word_q;
  assign step       = step_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign level      = level_q;

endmodule

// File: tb/tb_delay_sequencer.sv
// Bench for delay_sequencer: delay-counter stub, event monitor and a
// timeline model that predicts load/done cycles from the step list.
module tb_delay_sequencer;

  localparam int          DEPTH     = 4;
  localparam logic [47:0] MIN_DELAY = 48'd2;
  localparam int          BLANK     = 2;
  localparam logic [15:0] IDLE_WORD = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_valid;
  logic        push_ready;
  logic [47:0] push_delay;
  logic [15:0] push_word;
  logic        start;
  logic        abort;
  logic        dc_load;
  logic [47:0] dc_l;
  logic        dc_expired;
  logic [15:0] out_word;
  logic        step;
  logic        busy;
  logic        done;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  delay_sequencer #(
    .DEPTH(DEPTH), .MIN_DELAY(MIN_DELAY), .BLANK(BLANK), .IDLE_WORD(IDLE_WORD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_delay(push_delay), .push_word(push_word),
    .start(start), .abort(abort),
    .dc_load(dc_load), .dc_l(dc_l), .dc_expired(dc_expired),
    .out_word(out_word), .step(step), .busy(busy), .done(done), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Delay counter stub: expired exactly dc_l cycles after dc_load, dropped
  // by the next dc_load. stale_en additionally holds expired high for the
  // BLANK cycles after a load, imitating a slow-to-clear counter.
  logic [47:0] sc_cnt;
  logic        sc_armed;
  int          sc_stale;
  bit          stale_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_cnt   <= '0;
      sc_armed <= 1'b0;
      sc_stale <= 0;
    end else if (dc_load) begin
      sc_cnt   <= dc_l - 48'd1;
      sc_armed <= 1'b1;
      sc_stale <= stale_en ? BLANK : 0;
    end else begin
      if (sc_cnt != '0) sc_cnt <= sc_cnt - 48'd1;
      if (sc_stale > 0) sc_stale <= sc_stale - 1;
    end
  end
  assign dc_expired = (sc_armed && sc_cnt == '0) || (sc_stale > 0);

  // Event monitor
  int          ld_cyc[$];
  logic [47:0] ld_l[$];
  logic [15:0] ld_w[$];
  int          done_cyc[$];
  int          proto_err = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dc_load === 1'b1) begin
        ld_cyc.push_back(cyc);
        ld_l.push_back(dc_l);
        ld_w.push_back(out_word);
        if (busy !== 1'b1) proto_err++;
      end
      if (step !== dc_load) proto_err++;
      if (done === 1'b1) begin
        done_cyc.push_back(cyc);
        if (busy !== 1'b0 || out_word !== IDLE_WORD) proto_err++;
      end
    end
  end

  // Model input: steps expected to be played, in order.
  logic [47:0] md[$];
  logic [15:0] mw[$];

  task automatic clear_logs();
    ld_cyc.delete(); ld_l.delete(); ld_w.delete(); done_cyc.delete();
    md.delete(); mw.delete();
    proto_err = 0;
  endtask

  task automatic do_push(input logic [47:0] d, input logic [15:0] w);
    push_valid = 1'b1; push_delay = d; push_word = w;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic push_model(input logic [47:0] d, input logic [15:0] w);
    md.push_back(d); mw.push_back(w);
    do_push(d, w);
  endtask

  task automatic do_start(output int s);
    start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cyc.size() == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  // Timeline model: first load one cycle after start; each step occupies
  // max(clamped delay, BLANK+1) cycles until expiry is seen, plus one cycle
  // to the next load or to done.
  task automatic check_run(input string name, input int s);
    int t; int span; logic [47:0] dl;
    t = s + 1;
    total++;
    if (ld_cyc.size() != md.size()) begin
      bad++; $display("FAIL %s load_count got=%0d exp=%0d", name, ld_cyc.size(), md.size());
    end
    for (int i = 0; i < md.size(); i++) begin
      dl   = (md[i] < MIN_DELAY) ? MIN_DELAY : md[i];
      span = (dl > 48'(BLANK + 1)) ? int'(dl) : BLANK + 1;
      if (i < ld_cyc.size()) begin
        total++;
        if (ld_cyc[i] != t) begin
          bad++; $display("FAIL %s load%0d_cycle got=%0d exp=%0d", name, i, ld_cyc[i] - s, t - s);
        end
        total++;
        if (ld_l[i] !== dl) begin
          bad++; $display("FAIL %s load%0d_dc_l got=%0d exp=%0d", name, i, ld_l[i], dl);
        end
        total++;
        if (ld_w[i] !== mw[i]) begin
          bad++; $display("FAIL %s load%0d_word got=%h exp=%h", name, i, ld_w[i], mw[i]);
        end
      end
      t = t + span + 1;
    end
    total++;
    if (done_cyc.size() != 1) begin
      bad++; $display("FAIL %s done_count got=%0d exp=1", name, done_cyc.size());
    end else begin
      total++;
      if (done_cyc[0] != t) begin
        bad++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_cyc[0] - s, t - s);
      end
    end
    total++;
    if (proto_err != 0) begin
      bad++; $display("FAIL %s protocol_errors got=%0d exp=0", name, proto_err);
    end
  endtask

  task automatic test_reset();
    int s;
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL reset_push_ready got=%b exp=1", push_ready); end
    total++; if (dc_load !== 1'b0) begin bad++; $display("FAIL reset_dc_load got=%b exp=0", dc_load); end
    total++; if (dc_l !== 48'd0) begin bad++; $display("FAIL reset_dc_l got=%h exp=0", dc_l); end
    total++; if (out_word !== IDLE_WORD) begin bad++; $display("FAIL reset_out_word got=%h exp=%h", out_word, IDLE_WORD); end
    total++; if ({step, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_step_busy_done got=%b exp=000", {step, busy, done}); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    do_start(s);
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || ld_cyc.size() != 0) begin bad++; $display("FAIL reset_empty_start busy=%b loads=%0d exp busy=0 loads=0", busy, ld_cyc.size()); end
  endtask

  task automatic test_basic();
    int s;
    clear_logs();
    push_model(48'd10, 16'hA5A5);
    push_model(48'd20, 16'h5A5A);
    do_start(s);
    wait_done(100);
    check_run("basic", s);
    total++; if (out_word !== IDLE_WORD || busy !== 1'b0) begin bad++; $display("FAIL basic_after_done out_word=%h busy=%b exp %h/0", out_word, busy, IDLE_WORD); end
  endtask

  task automatic test_clamp();
    int s;
    clear_logs();
    stale_en = 1'b1;
    push_model(48'd0, 16'h0001);
    push_model(48'd1, 16'h0002);
    push_model(48'd7, 16'h0003);
    do_start(s);
    wait_done(100);
    stale_en = 1'b0;
    check_run("clamp_stale", s);
  endtask

  task automatic test_full();
    int s;
    clear_logs();
    push_model(48'd4, 16'h1111);
    push_model(48'd5, 16'h2222);
    push_model(48'd6, 16'h3333);
    push_model(48'd7, 16'h4444);
    total++; if (push_ready !== 1'b0 || level !== 3'd4) begin bad++; $display("FAIL full_flags ready=%b level=%0d exp 0/4", push_ready, level); end
    do_push(48'd9, 16'hDEAD);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL full_drop_level got=%0d exp=4", level); end
    do_start(s);
    @(negedge clk);
    total++; if (level !== 3'd3) begin bad++; $display("FAIL full_after_pop got=%0d exp=3", level); end
    for (int i = 0; i < 20 && dc_load !== 1'b1; i++) @(negedge clk);
    total++; if (dc_load !== 1'b1) begin bad++; $display("FAIL full_second_load got=%b exp=1", dc_load); end
    push_model(48'd3, 16'h5555);
    total++; if (level !== 3'd3) begin bad++; $display("FAIL full_push_pop_level got=%0d exp=3", level); end
    wait_done(100);
    check_run("full", s);
  endtask

  task automatic test_abort();
    int s;
    clear_logs();
    push_model(48'd8, 16'hAAA1);
    push_model(48'd8, 16'hAAA2);
    push_model(48'd8, 16'hAAA3);
    do_start(s);
    @(negedge clk);
    for (int i = 0; i < 20 && dc_load !== 1'b1; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    do_push(48'd5, 16'hBEEF);
    abort = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0 || level !== 3'd0 || out_word !== IDLE_WORD) begin
      bad++; $display("FAIL abort_next busy=%b level=%0d word=%h exp 0/0/%h", busy, level, out_word, IDLE_WORD); end
    repeat (30) @(negedge clk);
    total++; if (ld_cyc.size() != 2) begin bad++; $display("FAIL abort_loads got=%0d exp=2", ld_cyc.size()); end
    total++; if (done_cyc.size() != 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", done_cyc.size()); end
    total++; if (level !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL abort_settled level=%0d busy=%b exp 0/0", level, busy); end
  endtask

  task automatic test_extend();
    int s;
    clear_logs();
    push_model(48'd20, 16'hC001);
    do_start(s);
    repeat (15) @(negedge clk);
    push_model(48'd6, 16'hC002);
    wait_done(100);
    check_run("extend", s);
  endtask

  task automatic test_wide();
    int s;
    clear_logs();
    do_push(48'hFFFF_FFFF_FFFF, 16'h7777);
    do_start(s);
    total++; if (dc_load !== 1'b1 || dc_l !== 48'hFFFF_FFFF_FFFF || out_word !== 16'h7777) begin
      bad++; $display("FAIL wide_load load=%b dc_l=%h word=%h exp 1/ffffffffffff/7777", dc_load, dc_l, out_word); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || dc_l !== 48'hFFFF_FFFF_FFFF) begin
      bad++; $display("FAIL wide_hold busy=%b dc_l=%h exp 0/ffffffffffff", busy, dc_l); end
  endtask

  task automatic test_random();
    int s; int n; logic [47:0] d;
    for (int it = 0; it < 12; it++) begin
      clear_logs();
      stale_en = ($urandom_range(0, 1) == 1);
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        d = 48'($urandom_range(0, 12));
        push_model(d, 16'($urandom));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_start(s);
      wait_done(200);
      check_run("random", s);
    end
    stale_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int s; int busy_seen;
    clear_logs();
    do_push(48'd10, 16'hD001);
    do_push(48'd10, 16'hD002);
    do_push(48'd10, 16'hD003);
    do_start(s);
    repeat (5) @(negedge clk);
    total++; if (level !== 3'd2 || busy !== 1'b1) begin bad++; $display("FAIL rstmid_pre level=%0d busy=%b exp 2/1", level, busy); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (push_ready !== 1'b1 || dc_load !== 1'b0 || dc_l !== 48'd0 || out_word !== IDLE_WORD) begin
      bad++; $display("FAIL rstmid_outputs ready=%b load=%b dc_l=%h word=%h", push_ready, dc_load, dc_l, out_word); end
    total++; if ({step, busy, done} !== 3'b000 || level !== 3'd0) begin
      bad++; $display("FAIL rstmid_flags sbd=%b level=%0d exp 000/0", {step, busy, done}, level); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    do_start(s);
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy !== 1'b0) busy_seen++;
      @(negedge clk);
    end
    total++; if (busy_seen != 0 || ld_cyc.size() != 0 || done_cyc.size() != 0) begin
      bad++; $display("FAIL rstmid_after busy_cycles=%0d loads=%0d dones=%0d exp 0/0/0", busy_seen, ld_cyc.size(), done_cyc.size()); end
  endtask

  initial begin
    rst_n = 1'b0; push_valid = 1'b0; push_delay = '0; push_word = '0;
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_clamp();
    test_full();
    test_abort();
    test_extend();
    test_wide();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
